parking_lot_ctrl_param: RTL and testbench
=========================================

Name: parking_lot_ctrl_param

Overview:
- Parametrised successor of the fixed 7-floor parking-lot controller: floor count, plate width and fee rate are generic.
- Adds duration-based fee, sticky leakage blocking, request rejection and busy/handshake outputs.
- Sits between the plate-reader/request front end and the display/status logic; one elevator, one vehicle in transit at a time.
- Each floor has one SUV slot (upper half of floor word) and one sedan slot (lower half).

Parameters:
- NUM_FLOORS, 7, parking floors above ground floor 0; legal range 1..15.
- PLATE_W, 16, plate width (4 BCD digits at default); must be a multiple of 4.
- FEE_W, 8, fee output width.
- FEE_RATE, 1, cents per elapsed clock cycle parked.
- TS_W, 16, free-running timestamp counter width.
- Derived (localparam, not overridable): FLR_W = $clog2(NUM_FLOORS+1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- license_plate  input  PLATE_W  plate of the requesting vehicle.
- in_mode  input  1  park request, sampled in IDLE.
- out_mode  input  1  retrieve request, sampled in IDLE.
- leakage  input  1  leakage report strobe.
- leakage_floor  input  FLR_W  floor of leakage report; 0 = clear all.
- parked  output  NUM_FLOORS*2*PLATE_W  floor f word at [(f-1)*2*PLATE_W +: 2*PLATE_W], SUV in upper half; 0 = empty.
- current_floor  output  FLR_W  elevator position.
- moving  output  PLATE_W  plate in elevator; 0 = none.
- plate_type  output  1  type of last accepted plate; 1 = SUV.
- fee  output  FEE_W  fee of last retrieved vehicle, held.
- fee_valid  output  1  one-cycle pulse when fee updates.
- empty_suv / empty_sedan  output  4 each  free slots of each type on unblocked floors.
- full_suv / full_sedan  output  1 each  high when the matching empty count is 0.
- busy  output  1  high in every state except IDLE.
- reject  output  1  one-cycle pulse when a request is refused.

Behaviour:
- Reset (async, reset=0): all slots 0, moving 0, current_floor 0, fee 0, fee_valid 0, reject 0, plate_type 0, blocked mask 0, timestamp 0, state IDLE.
- Timestamp counts every cycle and wraps at 2^TS_W. Elapsed time is taken modulo 2^TS_W.
- Plate type: least-significant BCD digit odd = SUV, even = sedan.
- States: IDLE, LOAD, UP, PARK, FETCH_UP, PICK, DOWN, EXIT.
- IDLE, in_mode only:
  - Reject if plate = 0, plate already parked or in transit, or no free unblocked slot of its type.
  - Otherwise target = lowest unblocked floor with a free slot of that type; go to LOAD.
- LOAD (floor 0): moving = plate. Then UP.
- UP: floor +1 per cycle until it equals the target, then PARK.
- PARK: write plate to the slot, store entry timestamp, moving = 0. Then DOWN.
- IDLE, out_mode only:
  - Reject if plate = 0 or plate not found.
  - Otherwise go to FETCH_UP; floor +1 per cycle until the car's floor, then PICK.
  - Blocked floors are still served for retrieval.
- PICK: moving = plate, clear the slot, fee = min((ts_now - ts_entry) * FEE_RATE, 2^FEE_W - 1). Then DOWN.
- DOWN: floor -1 per cycle. At floor 0: EXIT if a car is aboard, otherwise IDLE.
- EXIT: moving = 0, fee_valid = 1. Then IDLE.
- Elevator moves at most one floor per cycle, always.
- Both in_mode and out_mode high in IDLE: reject, no action.
- Requests while busy: ignored, no reject.
- Leakage: accepted in any state.
  - leakage=1 with floor 1..NUM_FLOORS sets that floor's blocked bit (sticky).
  - leakage=1 with floor 0 clears all blocked bits.
  - Out-of-range floor: ignored.
  - A blocked floor is excluded from empty counts and target selection. A transfer already heading there completes.
- reject is asserted the cycle after the sampled request; state stays IDLE.
- Reset mid-transfer: immediate return to reset values; the car in transit is lost.

Optional Feature:
- Macro: PARKING_REQ_BUF_EN.
- Defined: one-entry request buffer. The first request (plate + mode) arriving while busy is captured and served on the cycle after IDLE is reached. Validity checks are made at service time. Further requests while the buffer is full get a reject pulse.
- Undefined: requests while busy are ignored as described above.

Test Plan:
- Reset, then in_mode with plate 0x9423 (SUV) -> busy next cycle; moving = 0x9423 at floor 0; floor 1; slot parked[31:16] = 0x9423; floor back to 0; empty_suv 7 -> 6.
- Then in_mode with 0x8754 (sedan) -> parked[15:0] = 0x8754 on floor 1; empty_sedan = 6.
- out_mode 0x8754, 20 cycles after its PARK -> PICK at floor 1, moving = 0x8754; fee = elapsed cycles (≈20, computed by bench); fee_valid pulses in EXIT; slot cleared.
- leakage=1, floor 1, then in_mode 0x1111 (SUV) -> parked on floor 2; empty_suv excludes floor 1. leakage=1, floor 0 -> blocked mask cleared.
- Fill all 7 SUV slots, then in_mode 0x3333 -> reject pulse; out_mode 0x5555 (absent) -> reject; in_mode and out_mode both high -> reject.
- Park 0x2222 and wait > 255 cycles -> retrieval fee = 255 (saturated). Also assert reset mid-UP -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/parking_lot_ctrl_param.sv
// Single-elevator parking controller: per-floor SUV/sedan slots, duration-based fee, sticky leakage blocking.
// Define PARKING_REQ_BUF_EN to capture one request that arrives while busy and serve it once IDLE returns.
module parking_lot_ctrl_param #(
  parameter int NUM_FLOORS = 7,
  parameter int PLATE_W    = 16,
  parameter int FEE_W      = 8,
  parameter int FEE_RATE   = 1,
  parameter int TS_W       = 16,
  localparam int FLR_W     = $clog2(NUM_FLOORS + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [PLATE_W-1:0]              license_plate,
  input  logic                            in_mode,
  input  logic                            out_mode,
  input  logic                            leakage,
  input  logic [FLR_W-1:0]                leakage_floor,
  output logic [NUM_FLOORS*2*PLATE_W-1:0] parked,
  output logic [FLR_W-1:0]                current_floor,
  output logic [PLATE_W-1:0]              moving,
  output logic                            plate_type,
  output logic [FEE_W-1:0]                fee,
  output logic                            fee_valid,
  output logic [3:0]                      empty_suv,
  output logic [3:0]                      empty_sedan,
  output logic                            full_suv,
  output logic                            full_sedan,
  output logic                            busy,
  output logic                            reject
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, PARK, FETCH_UP, PICK, DOWN, EXIT} state_t;

  localparam int PROD_W = TS_W + 32;
  localparam logic [FLR_W-1:0]  MAX_FLR = FLR_W'(NUM_FLOORS);
  localparam logic [PROD_W-1:0] FEE_MAX = PROD_W'({FEE_W{1'b1}});

  state_t                                r_state;
  logic [NUM_FLOORS-1:0][2*PLATE_W-1:0]  r_parked;
  logic [TS_W-1:0]                       r_entry [NUM_FLOORS][2];
  logic [NUM_FLOORS-1:0]                 r_blocked;
  logic [TS_W-1:0]                       r_ts;
  logic [FLR_W-1:0]                      r_floor;
  logic [FLR_W-1:0]                      r_target;
  logic                                  r_slotSuv;
  logic [PLATE_W-1:0]                    r_plate;
  logic [PLATE_W-1:0]                    r_moving;
  logic                                  r_plateType;
  logic [FEE_W-1:0]                      r_fee;
  logic                                  r_feeValid;
  logic                                  r_reject;

  logic [PLATE_W-1:0] w_reqPlate;
  logic               w_reqIn;
  logic               w_reqOut;
  logic               w_reqSuv;
  logic               w_found;
  logic [FLR_W-1:0]   w_foundFlr;
  logic               w_foundSuv;
  logic               w_hasFree;
  logic [FLR_W-1:0]   w_target;
  logic [3:0]         w_emptySuv;
  logic [3:0]         w_emptySedan;
  logic [FLR_W-1:0]   w_floorInc;
  logic [FLR_W-1:0]   w_tIdx;
  logic [TS_W-1:0]    w_elapsed;
  logic [PROD_W-1:0]  w_prod;
  logic [FEE_W-1:0]   w_feeNext;

`ifdef PARKING_REQ_BUF_EN
  logic               r_bufValid;
  logic               r_bufIn;
  logic               r_bufOut;
  logic [PLATE_W-1:0] r_bufPlate;

  // A buffered request takes priority over whatever is on the inputs in IDLE.
  assign w_reqPlate = r_bufValid ? r_bufPlate : license_plate;
  assign w_reqIn    = r_bufValid ? r_bufIn    : in_mode;
  assign w_reqOut   = r_bufValid ? r_bufOut   : out_mode;
`else
  assign w_reqPlate = license_plate;
  assign w_reqIn    = in_mode;
  assign w_reqOut   = out_mode;
`endif

  assign w_reqSuv   = w_reqPlate[0];
  assign w_floorInc = r_floor + 1'b1;
  assign w_tIdx     = r_target - 1'b1;

  always_comb begin
    w_found    = 1'b0;
    w_foundFlr = '0;
    w_foundSuv = 1'b0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (r_parked[f][2*PLATE_W-1:PLATE_W] == w_reqPlate) begin
        w_found    = 1'b1;
        w_foundFlr = FLR_W'(f + 1);
        w_foundSuv = 1'b1;
      end else if (r_parked[f][PLATE_W-1:0] == w_reqPlate) begin
        w_found    = 1'b1;
        w_foundFlr = FLR_W'(f + 1);
        w_foundSuv = 1'b0;
      end
    end
  end

  // Descending scan so the last hit is the lowest free, unblocked floor.
  always_comb begin
    w_hasFree    = 1'b0;
    w_target     = '0;
    w_emptySuv   = '0;
    w_emptySedan = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (!r_blocked[f]) begin
        if (r_parked[f][2*PLATE_W-1:PLATE_W] == '0) w_emptySuv = w_emptySuv + 4'd1;
        if (r_parked[f][PLATE_W-1:0] == '0) w_emptySedan = w_emptySedan + 4'd1;
        if ((w_reqSuv ? r_parked[f][2*PLATE_W-1:PLATE_W] : r_parked[f][PLATE_W-1:0]) == '0) begin
          w_hasFree = 1'b1;
          w_target  = FLR_W'(f + 1);
        end
      end
    end
  end

  // Elapsed time wraps with the timestamp; the product is wide enough never to overflow before saturation.
  assign w_elapsed = r_ts - r_entry[w_tIdx][r_slotSuv];
  assign w_prod    = PROD_W'(w_elapsed) * PROD_W'(FEE_RATE);
  assign w_feeNext = (w_prod > FEE_MAX) ? {FEE_W{1'b1}} : w_prod[FEE_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blocked <= '0;
    end else if (leakage) begin
      if (leakage_floor == '0) r_blocked <= '0;
      else if (leakage_floor <= MAX_FLR) r_blocked[leakage_floor - 1'b1] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_parked    <= '0;
      r_floor     <= '0;
      r_target    <= '0;
      r_slotSuv   <= 1'b0;
      r_plate     <= '0;
      r_moving    <= '0;
      r_plateType <= 1'b0;
      r_fee       <= '0;
      r_feeValid  <= 1'b0;
      r_reject    <= 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
        for (int s = 0; s < 2; s++) r_entry[f][s] <= '0;
      end
`ifdef PARKING_REQ_BUF_EN
      r_bufValid <= 1'b0;
      r_bufIn    <= 1'b0;
      r_bufOut   <= 1'b0;
      r_bufPlate <= '0;
`endif
    end else begin
      r_reject   <= 1'b0;
      r_feeValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_reqIn && w_reqOut) begin
            r_reject <= 1'b1;
          end else if (w_reqIn) begin
            if (w_reqPlate == '0 || w_found || r_moving == w_reqPlate || !w_hasFree) begin
              r_reject <= 1'b1;
            end else begin
              r_target    <= w_target;
              r_slotSuv   <= w_reqSuv;
              r_plate     <= w_reqPlate;
              r_plateType <= w_reqSuv;
              r_state     <= LOAD;
            end
          end else if (w_reqOut) begin
            if (w_reqPlate == '0 || !w_found) begin
              r_reject <= 1'b1;
            end else begin
              r_target    <= w_foundFlr;
              r_slotSuv   <= w_foundSuv;
              r_plate     <= w_reqPlate;
              r_plateType <= w_reqSuv;
              r_state     <= FETCH_UP;
            end
          end
        end
        LOAD: begin
          r_moving <= r_plate;
          r_state  <= UP;
        end
        UP, FETCH_UP: begin
          r_floor <= w_floorInc;
          if (w_floorInc == r_target) r_state <= (r_state == UP) ? PARK : PICK;
        end
        PARK: begin
          if (r_slotSuv) r_parked[w_tIdx][2*PLATE_W-1:PLATE_W] <= r_plate;
          else r_parked[w_tIdx][PLATE_W-1:0] <= r_plate;
          r_entry[w_tIdx][r_slotSuv] <= r_ts;
          r_moving <= '0;
          r_state  <= DOWN;
        end
        PICK: begin
          if (r_slotSuv) r_parked[w_tIdx][2*PLATE_W-1:PLATE_W] <= '0;
          else r_parked[w_tIdx][PLATE_W-1:0] <= '0;
          r_moving <= r_plate;
          r_fee    <= w_feeNext;
          r_state  <= DOWN;
        end
        DOWN: begin
          if (r_floor <= FLR_W'(1)) begin
            r_floor <= '0;
            r_state <= (r_moving != '0) ? EXIT : IDLE;
          end else begin
            r_floor <= r_floor - 1'b1;
          end
        end
        EXIT: begin
          r_moving   <= '0;
          r_feeValid <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef PARKING_REQ_BUF_EN
      if (r_state == IDLE) begin
        r_bufValid <= 1'b0;
      end else if (in_mode || out_mode) begin
        if (!r_bufValid) begin
          r_bufValid <= 1'b1;
          r_bufIn    <= in_mode;
          r_bufOut   <= out_mode;
          r_bufPlate <= license_plate;
        end else begin
          r_reject <= 1'b1;
        end
      end
`endif
    end
  end

  assign parked        = r_parked;
  assign current_floor = r_floor;
  assign moving        = r_moving;
  assign plate_type    = r_plateType;
  assign fee           = r_fee;
  assign fee_valid     = r_feeValid;
  assign empty_suv     = w_emptySuv;
  assign empty_sedan   = w_emptySedan;
  assign full_suv      = (w_emptySuv == 4'd0);
  assign full_sedan    = (w_emptySedan == 4'd0);
  assign busy          = (r_state != IDLE);
  assign reject        = r_reject;

endmodule

// File: tb/tb_parking_lot_ctrl_param.sv
// Directed self-checking bench for parking_lot_ctrl_param at default parameters (7 floors, 16-bit plates, 8-bit fee).
module tb_parking_lot_ctrl_param;

  localparam int NF = 7;
  localparam int PW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [PW-1:0]     license_plate = '0;
  logic              in_mode = 1'b0;
  logic              out_mode = 1'b0;
  logic              leakage = 1'b0;
  logic [2:0]        leakage_floor = '0;
  logic [NF*2*PW-1:0] parked;
  logic [2:0]        current_floor;
  logic [PW-1:0]     moving;
  logic              plate_type;
  logic [7:0]        fee;
  logic              fee_valid;
  logic [3:0]        empty_suv;
  logic [3:0]        empty_sedan;
  logic              full_suv;
  logic              full_sedan;
  logic              busy;
  logic              reject;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tParked = -1;

  parking_lot_ctrl_param dut (
    .clock(clock), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor),
    .parked(parked), .current_floor(current_floor), .moving(moving), .plate_type(plate_type),
    .fee(fee), .fee_valid(fee_valid), .empty_suv(empty_suv), .empty_sedan(empty_sedan),
    .full_suv(full_suv), .full_sedan(full_sedan), .busy(busy), .reject(reject)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] slotOf(input int flr, input bit suv);
    return parked[(flr - 1) * 32 + (suv ? 16 : 0) +: 16];
  endfunction

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic parkCar(input logic [15:0] p, output bit ok);
    license_plate = p;
    in_mode = 1'b1;
    tick();
    in_mode = 1'b0;
    waitIdle(40, ok);
  endtask

  task automatic fetchCar(input logic [15:0] p, output bit ok);
    license_plate = p;
    out_mode = 1'b1;
    tick();
    out_mode = 1'b0;
    waitIdle(40, ok);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h want 0", busy); end
    checks++; if (moving !== 16'h0) begin errors++; $display("[TB] FAIL reset_moving: got %h want 0000", moving); end
    checks++; if (current_floor !== 3'd0) begin errors++; $display("[TB] FAIL reset_floor: got %0d want 0", current_floor); end
    checks++; if (parked !== '0) begin errors++; $display("[TB] FAIL reset_parked: got %h want 0", parked); end
    checks++; if (fee !== 8'd0 || fee_valid !== 1'b0 || reject !== 1'b0) begin errors++; $display("[TB] FAIL reset_fee: got fee %0d fv %0b rej %0b want 0 0 0", fee, fee_valid, reject); end
    checks++; if (empty_suv !== 4'd7 || empty_sedan !== 4'd7) begin errors++; $display("[TB] FAIL reset_empty: got %0d/%0d want 7/7", empty_suv, empty_sedan); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_park_suv();
    license_plate = 16'h9423;
    in_mode = 1'b1;
    tick();
    in_mode = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL park_busy: got %0b want 1", busy); end
    tick();
    checks++; if (moving !== 16'h9423 || current_floor !== 3'd0) begin errors++; $display("[TB] FAIL park_load: got %h@%0d want 9423@0", moving, current_floor); end
    tick();
    checks++; if (current_floor !== 3'd1) begin errors++; $display("[TB] FAIL park_up: got floor %0d want 1", current_floor); end
    tick();
    checks++; if (slotOf(1, 1'b1) !== 16'h9423 || moving !== 16'h0) begin errors++; $display("[TB] FAIL park_slot: got %h mv %h want 9423 mv 0000", slotOf(1, 1'b1), moving); end
    tick();
    checks++; if (current_floor !== 3'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL park_down: got floor %0d busy %0b want 0 0", current_floor, busy); end
    checks++; if (empty_suv !== 4'd6 || plate_type !== 1'b1) begin errors++; $display("[TB] FAIL park_count: got %0d type %0b want 6 1", empty_suv, plate_type); end
  endtask

  task automatic test_park_sedan();
    license_plate = 16'h8754;
    in_mode = 1'b1;
    tick();
    in_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tParked < 0 && slotOf(1, 1'b0) == 16'h8754) tParked = cyc;
      if (!busy) break;
      tick();
    end
    checks++; if (tParked < 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL sedan_park: got seen %0d busy %0b want seen busy 0", tParked, busy); end
    checks++; if (empty_sedan !== 4'd6 || plate_type !== 1'b0) begin errors++; $display("[TB] FAIL sedan_count: got %0d type %0b want 6 0", empty_sedan, plate_type); end
  endtask

  task automatic test_retrieve_fee();
    int tPick = -1;
    int fvCount = 0;
    bit sawCarry = 1'b0;
    for (int i = 0; i < 40 && cyc < tParked + 20; i++) tick();
    license_plate = 16'h8754;
    out_mode = 1'b1;
    tick();
    out_mode = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (moving == 16'h8754 && current_floor == 3'd1) sawCarry = 1'b1;
      if (tPick < 0 && slotOf(1, 1'b0) == 16'h0) tPick = cyc;
      if (fee_valid) fvCount++;
      if (!busy) break;
      tick();
    end
    checks++; if (sawCarry !== 1'b1) begin errors++; $display("[TB] FAIL fetch_carry: got %0b want 1", sawCarry); end
    checks++; if (tPick < 0 || fee !== 8'(tPick - tParked)) begin errors++; $display("[TB] FAIL fetch_fee: got %0d want %0d", fee, tPick - tParked); end
    checks++; if (fvCount != 1) begin errors++; $display("[TB] FAIL fetch_fee_valid: got %0d pulses want 1", fvCount); end
    checks++; if (empty_sedan !== 4'd7 || moving !== 16'h0) begin errors++; $display("[TB] FAIL fetch_clear: got %0d mv %h want 7 0000", empty_sedan, moving); end
  endtask

  task automatic test_leakage();
    bit ok;
    leakage = 1'b1;
    leakage_floor = 3'd1;
    tick();
    leakage = 1'b0;
    checks++; if (empty_sedan !== 4'd6 || empty_suv !== 4'd6) begin errors++; $display("[TB] FAIL leak_block: got %0d/%0d want 6/6", empty_suv, empty_sedan); end
    parkCar(16'h1111, ok);
    checks++; if (!ok || slotOf(2, 1'b1) !== 16'h1111) begin errors++; $display("[TB] FAIL leak_target: got %h want 1111 on floor 2", slotOf(2, 1'b1)); end
    checks++; if (empty_suv !== 4'd5) begin errors++; $display("[TB] FAIL leak_count: got %0d want 5", empty_suv); end
    leakage = 1'b1;
    leakage_floor = 3'd0;
    tick();
    leakage = 1'b0;
    checks++; if (empty_sedan !== 4'd7 || empty_suv !== 4'd5) begin errors++; $display("[TB] FAIL leak_clear: got %0d/%0d want 5/7", empty_suv, empty_sedan); end
  endtask

  task automatic test_full_reject();
    bit ok;
    bit allOk = 1'b1;
    logic [15:0] fills [5] = '{16'h0011, 16'h0013, 16'h0015, 16'h0017, 16'h0019};
    logic [15:0] rPlate [4] = '{16'h3333, 16'h5555, 16'h1234, 16'h0000};
    logic rIn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic rOut [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      parkCar(fills[i], ok);
      allOk &= ok;
    end
    checks++; if (!allOk || full_suv !== 1'b1 || empty_suv !== 4'd0) begin errors++; $display("[TB] FAIL full_suv: got full %0b cnt %0d want 1 0", full_suv, empty_suv); end
    checks++; if (slotOf(7, 1'b1) !== 16'h0019) begin errors++; $display("[TB] FAIL full_top: got %h want 0019", slotOf(7, 1'b1)); end
    for (int i = 0; i < 4; i++) begin
      license_plate = rPlate[i];
      in_mode = rIn[i];
      out_mode = rOut[i];
      tick();
      in_mode = 1'b0;
      out_mode = 1'b0;
      checks++; if (reject !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reject_%0d: got rej %0b busy %0b want 1 0", i, reject, busy); end
      tick();
      checks++; if (reject !== 1'b0) begin errors++; $display("[TB] FAIL reject_pulse_%0d: got %0b want 0", i, reject); end
    end
  endtask

  task automatic test_fee_saturation();
    bit ok;
    parkCar(16'h2222, ok);
    checks++; if (!ok || slotOf(1, 1'b0) !== 16'h2222) begin errors++; $display("[TB] FAIL sat_park: got %h want 2222", slotOf(1, 1'b0)); end
    for (int i = 0; i < 300; i++) tick();
    fetchCar(16'h2222, ok);
    checks++; if (!ok || fee !== 8'd255) begin errors++; $display("[TB] FAIL sat_fee: got %0d want 255", fee); end
    checks++; if (slotOf(1, 1'b0) !== 16'h0) begin errors++; $display("[TB] FAIL sat_clear: got %h want 0000", slotOf(1, 1'b0)); end
  endtask

  task automatic test_reset_mid_up();
    bit ok;
    parkCar(16'h4444, ok);
    license_plate = 16'h4446;
    in_mode = 1'b1;
    tick();
    in_mode = 1'b0;
    tick();
    tick();
    checks++; if (!ok || current_floor !== 3'd1 || moving !== 16'h4446) begin errors++; $display("[TB] FAIL midup_state: got %h@%0d want 4446@1", moving, current_floor); end
    #1 reset = 1'b0;
    #1;
    checks++; if (current_floor !== 3'd0 || moving !== 16'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midup_reset: got floor %0d mv %h busy %0b want 0 0000 0", current_floor, moving, busy); end
    checks++; if (parked !== '0 || fee !== 8'd0 || plate_type !== 1'b0) begin errors++; $display("[TB] FAIL midup_regs: got fee %0d type %0b want 0 0 with empty slots", fee, plate_type); end
    checks++; if (empty_suv !== 4'd7 || empty_sedan !== 4'd7 || full_suv !== 1'b0) begin errors++; $display("[TB] FAIL midup_counts: got %0d/%0d want 7/7", empty_suv, empty_sedan); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit sawReject = 1'b0;
    license_plate = 16'h6668;
    in_mode = 1'b1;
    tick();
    license_plate = 16'h7770;
    tick();
    in_mode = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (reject) sawReject = 1'b1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!ok || sawReject !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_reject: got %0b want 0", sawReject); end
    checks++; if (slotOf(1, 1'b0) !== 16'h6668 || slotOf(2, 1'b0) !== 16'h0) begin errors++; $display("[TB] FAIL busy_ignore_slots: got %h/%h want 6668/0000", slotOf(1, 1'b0), slotOf(2, 1'b0)); end
  endtask

  initial begin
    test_reset();
    test_park_suv();
    test_park_sedan();
    test_retrieve_fee();
    test_leakage();
    test_full_reject();
    test_fee_saturation();
    test_reset_mid_up();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
